// File: rtl/ps2_kb_rx_fifo_if.sv
// rtl/ps2_kb_rx_fifo_if.sv - key event stream between the PS/2 receiver and its consumer
interface ps2_kb_rx_fifo_if;
  logic [7:0] Key_Code;
  logic       Key_Release;
  logic       Key_Extended;
  logic       Key_Valid;
  logic       Key_Ready;

  modport master (output Key_Code, Key_Release, Key_Extended, Key_Valid, input Key_Ready);
  modport slave  (input Key_Code, Key_Release, Key_Extended, Key_Valid, output Key_Ready);
endinterface

// File: rtl/ps2_kb_rx_fifo.sv
// rtl/ps2_kb_rx_fifo.sv - PS/2 keyboard receiver: filtered sampling, frame check,
// make/break/extended decode and a show-ahead event FIFO.
module ps2_kb_rx_fifo #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        KB_Clk,
  input  logic                        KB_Data,
  ps2_kb_rx_fifo_if.master            kb,
  output logic [$clog2(FIFO_DEPTH):0] Fifo_Count,
  output logic                        Parity_Err,
  output logic                        Frame_Err,
  output logic                        Overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RECV  = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;

  logic [1:0]    clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
  logic          filt_q, filt_d;
  logic [7:0]    fcnt_q, fcnt_d;
  logic          fall;
  logic [1:0]    state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [10:0]   frame_q, frame_d;
  logic [WW-1:0] wd_q, wd_d;
  logic          perr_q, perr_d, ferr_q, ferr_d;
  logic          byte_vld_q, byte_vld_d;
  logic [7:0]    byte_q, byte_d;
  logic          rel_p_q, rel_p_d, ext_p_q, ext_p_d;
  logic          emit;
  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [9:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          empty, full, push, pop;
  logic [9:0]    head;

  // The filtered level only moves after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    clk_sync_d = {clk_sync_q[0], KB_Clk};
    dat_sync_d = {dat_sync_q[0], KB_Data};
    filt_d     = filt_q;
    fcnt_d     = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (fcnt_q == 8'(FILTER_LEN - 1)) filt_d = ~filt_q;
      else fcnt_d = fcnt_q + 8'd1;
    end
  end

  assign fall = filt_q & ~filt_d;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    frame_d    = frame_q;
    wd_d       = '0;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;
    byte_vld_d = 1'b0;
    byte_d     = frame_q[8:1];
    case (state_q)
      IDLE: if (fall) begin
        frame_d[0] = dat_sync_q[1];
        bit_cnt_d  = 4'd1;
        state_d    = RECV;
      end
      RECV: begin
        if (fall) begin
          frame_d[bit_cnt_q] = dat_sync_q[1];
          bit_cnt_d          = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd10) state_d = CHECK;
        end else if (wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
          ferr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (frame_q[0] || !frame_q[10]) ferr_d = 1'b1;
        else if (!(^frame_q[9:1]))      perr_d = 1'b1;
        else                            byte_vld_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rel_p_d = rel_p_q;
    ext_p_d = ext_p_q;
    emit    = 1'b0;
    if (perr_q || ferr_q) begin
      rel_p_d = 1'b0;
      ext_p_d = 1'b0;
    end else if (byte_vld_q) begin
      if (byte_q == 8'hF0)      rel_p_d = 1'b1;
      else if (byte_q == 8'hE0) ext_p_d = 1'b1;
      else begin
        emit    = 1'b1;
        rel_p_d = 1'b0;
        ext_p_d = 1'b0;
      end
    end
  end

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(FIFO_DEPTH));
  assign pop   = !empty && kb.Key_Ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the event.
  assign push  = emit && (!full || pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (push) begin
      mem_d[wr_ptr_q] = {ext_p_q, rel_p_q, byte_q};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (emit && !push) ovf_d = 1'b1;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      filt_q     <= 1'b1;
      fcnt_q     <= '0;
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      frame_q    <= '0;
      wd_q       <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      byte_vld_q <= 1'b0;
      byte_q     <= '0;
      rel_p_q    <= 1'b0;
      ext_p_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      frame_q    <= frame_d;
      wd_q       <= wd_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      byte_vld_q <= byte_vld_d;
      byte_q     <= byte_d;
      rel_p_q    <= rel_p_d;
      ext_p_q    <= ext_p_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge Clk) mem_q <= mem_d;

  assign head            = mem_q[rd_ptr_q];
  assign kb.Key_Code     = empty ? 8'h00 : head[7:0];
  assign kb.Key_Release  = !empty && head[8];
  assign kb.Key_Extended = !empty && head[9];
  assign kb.Key_Valid    = !empty;
  assign Fifo_Count      = cnt_q;
  assign Parity_Err      = perr_q;
  assign Frame_Err       = ferr_q;
  assign Overflow        = ovf_q;
endmodule
